// File: rtl/avalon_pio_array.sv
// Avalon-MM PIO array: RW output channels, synchronised input channels with
// edge capture and maskable interrupt, and a show-ahead command FIFO.
module avalon_pio_array #(
  parameter int DATA_W     = 32,
  parameter int NUM_OUT    = 4,
  parameter int NUM_IN     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 4
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic [ADDR_W-1:0]         avs_address,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [DATA_W-1:0]         avs_writedata,
  input  logic [DATA_W/8-1:0]       avs_byteenable,
  output logic [DATA_W-1:0]         avs_readdata,
  output logic                      irq,
  output logic [NUM_OUT*DATA_W-1:0] pio_out,
  input  logic [NUM_IN*DATA_W-1:0]  pio_in,
  output logic [DATA_W-1:0]         cmd_data,
  output logic                      cmd_valid,
  input  logic                      cmd_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] A_EDGE = ADDR_W'(NUM_OUT + NUM_IN);
  localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(NUM_OUT + NUM_IN + 1);
  localparam logic [ADDR_W-1:0] A_CMD  = ADDR_W'(NUM_OUT + NUM_IN + 2);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NUM_OUT + NUM_IN + 3);
  localparam logic [DATA_W-1:0] OVF_CLR_MASK = DATA_W'(32'h0004_0000);

  logic [NUM_OUT*DATA_W-1:0] out_q, out_d;
  logic [NUM_IN*DATA_W-1:0]  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [NUM_IN-1:0]         edge_q, edge_d, edge_seen;
  logic [NUM_IN:0]           mask_q, mask_d;
  logic [1:0]                arm_q, arm_d;
  logic                      irq_q, irq_d, ovf_q, ovf_d;
  logic [DATA_W-1:0]         rdata_q, rdata_d, be_bits;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [DATA_W-1:0]         mem [FIFO_DEPTH];
  logic                      push_req, push, pop, full;
  logic [31:0]               status;

  assign pio_out      = out_q;
  assign avs_readdata = rdata_q;
  assign irq          = irq_q;
  assign cmd_valid    = (count_q != '0);
  assign cmd_data     = mem[rd_ptr_q];

  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no latches are inferred.
    out_d   = out_q;
    mask_d  = mask_q;
    sync1_d = pio_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    arm_d   = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;

    for (int b = 0; b < DATA_W / 8; b++) be_bits[b*8 +: 8] = {8{avs_byteenable[b]}};

    for (int k = 0; k < NUM_OUT; k++)
      if (avs_write && avs_address == ADDR_W'(k))
        out_d[k*DATA_W +: DATA_W] = (out_q[k*DATA_W +: DATA_W] & ~be_bits) | (avs_writedata & be_bits);

    if (avs_write && avs_address == A_MASK)
      mask_d = (mask_q & ~be_bits[NUM_IN:0]) | (avs_writedata[NUM_IN:0] & be_bits[NUM_IN:0]);

    for (int i = 0; i < NUM_IN; i++)
      edge_seen[i] = (sync2_q[i*DATA_W +: DATA_W] != prev_q[i*DATA_W +: DATA_W]);

    // A new edge overrides a simultaneous write-1-to-clear of the same bit.
    edge_d = edge_q;
    if (avs_write && avs_address == A_EDGE) edge_d = edge_q & ~avs_writedata[NUM_IN-1:0];
    if (arm_q == 2'd3) edge_d = edge_d | edge_seen;

    pop      = cmd_valid && cmd_ready;
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    push_req = avs_write && (avs_address == A_CMD);
    push     = push_req && (!full || pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CNT_W'(1);
    if (!push && pop) count_d = count_q - CNT_W'(1);

    ovf_d = ovf_q;
    if (avs_write && avs_address == A_STAT && |(avs_writedata & OVF_CLR_MASK)) ovf_d = 1'b0;
    if (push_req && full && !pop) ovf_d = 1'b1;

    irq_d = |(edge_q & mask_q[NUM_IN-1:0]) | (mask_q[NUM_IN] & ovf_q);

    status  = {13'd0, ovf_q, full, !cmd_valid, 16'(count_q)};
    rdata_d = rdata_q;
    if (avs_read) begin
      rdata_d = '0;
      for (int k = 0; k < NUM_OUT; k++)
        if (avs_address == ADDR_W'(k)) rdata_d = out_q[k*DATA_W +: DATA_W];
      for (int i = 0; i < NUM_IN; i++)
        if (avs_address == ADDR_W'(NUM_OUT + i)) rdata_d = sync2_q[i*DATA_W +: DATA_W];
      if (avs_address == A_EDGE) rdata_d = DATA_W'(edge_q);
      if (avs_address == A_MASK) rdata_d = DATA_W'(mask_q);
      if (avs_address == A_STAT) rdata_d = DATA_W'(status);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      arm_q    <= '0;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
      out_q    <= out_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      arm_q    <= arm_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: FIFO storage has no reset; the count and pointers alone define which entries are valid.
  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr_q] <= avs_writedata;
  end

endmodule

// File: tb/tb_avalon_pio_array.sv
// Directed self-checking bench for avalon_pio_array at default parameters
// (32-bit data, 4 outputs, 4 inputs, 8-entry FIFO; STATUS at word 11).
module tb_avalon_pio_array;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n = 1'b0;
  logic [3:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [3:0]    avs_byteenable = '0;
  logic [31:0]   avs_readdata;
  logic          irq;
  logic [127:0]  pio_out;
  logic [127:0]  pio_in = '0;
  logic [31:0]   cmd_data;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd;

  localparam logic [3:0] A_IN0 = 4'd4, A_EDGE = 4'd8, A_MASK = 4'd9, A_CMD = 4'd10, A_STAT = 4'd11;

  avalon_pio_array dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .irq(irq), .pio_out(pio_out), .pio_in(pio_in),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk_clk);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk_clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk_clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with channel 0 already at 5 when reset releases
    pio_in[31:0] = 32'h5;
    repeat (3) @(negedge clk_clk);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    check("rst_pio_out", pio_out[31:0] | pio_out[63:32] | pio_out[95:64] | pio_out[127:96], 32'd0);
    reset_reset_n = 1'b1;

    for (int a = 0; a < 16; a++) begin
      bus_read(4'(a), rd);
      check($sformatf("sweep_addr%0d", a), rd,
            (a == 4) ? 32'h5 : (a == 11) ? 32'h0001_0000 : 32'h0);
    end

    // Output register full write then byte-lane write
    bus_write(4'd1, 32'hDEAD_BEEF, 4'hF);
    check("out1_full", pio_out[63:32], 32'hDEAD_BEEF);
    @(negedge clk_clk);
    avs_address = 4'd1; avs_writedata = 32'h0000_00AA; avs_byteenable = 4'b0001; avs_write = 1'b1;
    #1 check("out1_before_edge", pio_out[63:32], 32'hDEAD_BEEF);
    @(negedge clk_clk);
    avs_write = 1'b0;
    check("out1_byte", pio_out[63:32], 32'hDEAD_BEAA);
    bus_read(4'd1, rd);
    check("out1_readback", rd, 32'hDEAD_BEAA);
    @(negedge clk_clk);
    check("readdata_hold", avs_readdata, 32'hDEAD_BEAA);

    // Simultaneous read and write returns the pre-write value
    @(negedge clk_clk);
    avs_address = 4'd2; avs_writedata = 32'h1234_5678; avs_byteenable = 4'hF;
    avs_write = 1'b1; avs_read = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0; avs_read = 1'b0;
    check("rw_same_cycle", avs_readdata, 32'h0);
    bus_read(4'd2, rd);
    check("out2_after_rw", rd, 32'h1234_5678);

    // Edge capture timing and interrupt
    pio_in[31:0] = 32'h0;
    repeat (5) @(negedge clk_clk);
    bus_write(A_EDGE, 32'h1, 4'hF);
    bus_read(A_EDGE, rd);
    check("edge_w1c_clear", rd, 32'h0);
    bus_write(A_MASK, 32'h1, 4'hF);
    @(negedge clk_clk);
    pio_in[31:0] = 32'h3;
    @(negedge clk_clk);
    @(negedge clk_clk);
    avs_address = A_EDGE; avs_read = 1'b1;
    @(negedge clk_clk);
    check("edge_before_3rd", avs_readdata, 32'h0);
    check("irq_before_edge", {31'd0, irq}, 32'd0);
    @(negedge clk_clk);
    avs_read = 1'b0;
    check("edge_after_3rd", avs_readdata, 32'h1);
    check("irq_after_edge", {31'd0, irq}, 32'd1);

    // Clear collides with a new edge: set wins
    pio_in[31:0] = 32'h7;
    @(negedge clk_clk);
    @(negedge clk_clk);
    avs_address = A_EDGE; avs_writedata = 32'h1; avs_byteenable = 4'hF; avs_write = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0;
    bus_read(A_EDGE, rd);
    check("edge_set_wins", rd, 32'h1);
    bus_write(A_EDGE, 32'h1, 4'hF);
    @(negedge clk_clk);
    check("irq_after_clear", {31'd0, irq}, 32'd0);

    // Overflow with consumer stalled
    bus_write(A_MASK, 32'h10, 4'hF);
    for (int w = 1; w <= 9; w++) bus_write(A_CMD, 32'(w), 4'hF);
    bus_read(A_STAT, rd);
    check("status_full_ovf", rd, 32'h0006_0008);
    check("irq_ovf", {31'd0, irq}, 32'd1);
    check("head_first", cmd_data, 32'd1);
    bus_write(A_STAT, 32'h0004_0000, 4'hF);
    @(negedge clk_clk);
    check("irq_ovf_cleared", {31'd0, irq}, 32'd0);
    bus_read(A_STAT, rd);
    check("status_ovf_cleared", rd, 32'h0002_0008);

    // Drain in order, one per cycle
    @(negedge clk_clk);
    cmd_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("drain_%0d", k), cmd_data, 32'(k));
      @(negedge clk_clk);
    end
    check("drained_empty", {31'd0, cmd_valid}, 32'd0);

    // Back-to-back pushes with consumer ready
    avs_address = A_CMD; avs_byteenable = 4'hF; avs_writedata = 32'hA; avs_write = 1'b1;
    #1 check("bb_valid_before", {31'd0, cmd_valid}, 32'd0);
    @(negedge clk_clk);
    check("bb_valid_a", {31'd0, cmd_valid}, 32'd1);
    check("bb_data_a", cmd_data, 32'hA);
    avs_writedata = 32'hB;
    @(negedge clk_clk);
    check("bb_data_b", cmd_data, 32'hB);
    avs_writedata = 32'hC;
    @(negedge clk_clk);
    avs_write = 1'b0;
    check("bb_data_c", cmd_data, 32'hC);
    @(negedge clk_clk);
    check("bb_empty", {31'd0, cmd_valid}, 32'd0);

    // Full FIFO with simultaneous push and pop
    cmd_ready = 1'b0;
    for (int w = 0; w < 8; w++) bus_write(A_CMD, 32'h100 + 32'(w), 4'hF);
    @(negedge clk_clk);
    avs_address = A_CMD; avs_writedata = 32'h1FF; avs_write = 1'b1; cmd_ready = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0; cmd_ready = 1'b0;
    bus_read(A_STAT, rd);
    check("full_pushpop_status", rd, 32'h0002_0008);
    cmd_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("pushpop_order_%0d", k), cmd_data, (k == 8) ? 32'h1FF : 32'h100 + 32'(k));
      @(negedge clk_clk);
    end
    check("pushpop_empty", {31'd0, cmd_valid}, 32'd0);

    // Asynchronous reset with entries queued
    cmd_ready = 1'b0;
    for (int w = 0; w < 5; w++) bus_write(A_CMD, 32'h50 + 32'(w), 4'hF);
    bus_read(A_STAT, rd);
    check("five_queued", rd, 32'h0000_0005);
    @(posedge clk_clk);
    #2 reset_reset_n = 1'b0;
    #1 check("async_rst_valid", {31'd0, cmd_valid}, 32'd0);
    check("async_rst_pio_out", pio_out[63:32], 32'h0);
    check("async_rst_readdata", avs_readdata, 32'h0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    bus_read(A_STAT, rd);
    check("post_rst_status", rd, 32'h0001_0000);

    // Unmapped write is ignored
    bus_write(4'd13, 32'hFFFF_FFFF, 4'hF);
    bus_read(4'd13, rd);
    check("unmapped", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
